// File: rtl/mac_step_sequencer_pkg.sv
// Shared types and defaults for the MAC step sequencer.
// Optional stall counter: SEQ_STALL_PERF_EN.
package mac_step_sequencer_pkg;

  localparam int DEF_CNT_W    = 5;
  localparam int DEF_LAST_CNT = 24;
  localparam int STEPS        = DEF_LAST_CNT + 1;
  localparam int DEF_PERF_W   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

endpackage

// File: rtl/mac_step_counter.sv
// Step counter: clear, enable, and hold at the terminal count.
// Reports at_last when cnt sits on LAST_CNT.
module mac_step_counter
  import mac_step_sequencer_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LAST_CNT = DEF_LAST_CNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             at_last
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_CNT);

  assign at_last = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !at_last) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mac_step_sequencer.sv
// 25-step MAC pass sequencer with stall and result handshake.
// Optional stall_cycles output: SEQ_STALL_PERF_EN.
module mac_step_sequencer
  import mac_step_sequencer_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LAST_CNT = DEF_LAST_CNT
`ifdef SEQ_STALL_PERF_EN
  ,
  parameter int PERF_W   = DEF_PERF_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              src_valid,
  input  logic              sink_ready,
`ifdef SEQ_STALL_PERF_EN
  output logic [PERF_W-1:0] stall_cycles,
`endif
  output logic [CNT_W-1:0]  cnt,
  output logic              step_en,
  output logic              acc_clr,
  output logic              first,
  output logic              last,
  output logic              busy,
  output logic              result_valid
);

  seq_state_t state, state_d;
  logic       at_last;
  logic       cnt_clr;
  logic       acc_clr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc_clr <= 1'b0;
    end else begin
      state   <= state_d;
      acc_clr <= acc_clr_d;
    end
  end

  always_comb begin
    state_d      = state;
    step_en      = 1'b0;
    result_valid = 1'b0;
    acc_clr_d    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_d   = RUN;
          acc_clr_d = 1'b1;
        end
      end
      RUN: begin
        step_en = src_valid;
        if (abort)                   state_d = IDLE;
        else if (step_en && at_last) state_d = DRAIN;
      end
      DRAIN: begin
        result_valid = 1'b1;
        if (abort || sink_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state != IDLE);
  assign first = step_en && (cnt == '0);
  assign last  = step_en && at_last;

  // Zero the count on entry to a pass and whenever we head back to IDLE.
  assign cnt_clr = (state == IDLE) || (state_d == IDLE);

  mac_step_counter #(
    .CNT_W    (CNT_W),
    .LAST_CNT (LAST_CNT)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (step_en),
    .cnt     (cnt),
    .at_last (at_last)
  );

`ifdef SEQ_STALL_PERF_EN
  logic stall_now;

  assign stall_now = ((state == RUN) && !src_valid) ||
                     ((state == DRAIN) && !sink_ready);

  // The acc_clr cycle restarts the count but still counts its own stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (acc_clr) begin
      stall_cycles <= PERF_W'(stall_now);
    end else if (stall_now && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mac_step_sequencer.sv
// Scoreboard bench for mac_step_sequencer; set SEQ_STALL_PERF_EN
// to also check stall_cycles.
module tb_mac_step_sequencer;
  import mac_step_sequencer_pkg::*;

  localparam int LC = DEF_LAST_CNT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic src_valid = 1'b0;
  logic sink_ready = 1'b0;
  logic [DEF_CNT_W-1:0] cnt;
  logic step_en, acc_clr, first, last, busy, result_valid;
`ifdef SEQ_STALL_PERF_EN
  logic [DEF_PERF_W-1:0] stall_cycles;
`endif

  mac_step_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .src_valid    (src_valid),
    .sink_ready   (sink_ready),
`ifdef SEQ_STALL_PERF_EN
    .stall_cycles (stall_cycles),
`endif
    .cnt          (cnt),
    .step_en      (step_en),
    .acc_clr      (acc_clr),
    .first        (first),
    .last         (last),
    .busy         (busy),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_steps[$];
  int exp_results[$];
  int exp_clr = 0;
  int handshakes = 0;
  int pass_id = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_pass();
    for (int k = 0; k < STEPS; k++) exp_steps.push_back(k);
    exp_results.push_back(pass_id);
    exp_clr++;
    pass_id++;
  endtask

  task automatic flush();
    exp_steps.delete();
    exp_results.delete();
    exp_clr = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every observed step/clear/handshake must have been expected.
  always @(negedge clk) begin
    if (!rst) begin
      if (step_en) begin
        if (exp_steps.size() == 0) begin
          check("unexpected_step", 1, 0);
        end else begin
          int e;
          e = exp_steps.pop_front();
          check("sb_cnt", int'(cnt), e);
          check("sb_first", int'(first), int'(e == 0));
          check("sb_last", int'(last), int'(e == LC));
        end
      end else begin
        check("sb_idle_flags", int'(first | last), 0);
      end
      if (acc_clr) begin
        check("sb_clr_expected", int'(exp_clr > 0), 1);
        if (exp_clr > 0) exp_clr--;
      end
      if (result_valid && sink_ready) begin
        handshakes++;
        check("sb_result_expected", int'(exp_results.size() > 0), 1);
        check("sb_steps_done", exp_steps.size(), 0);
        check("sb_result_cnt", int'(cnt), LC);
        if (exp_results.size() > 0) void'(exp_results.pop_front());
      end
    end
  end

  task automatic free_run(input string tag);
    cyc();
    start = 1'b1; src_valid = 1'b1; sink_ready = 1'b1;
    push_pass();
    for (int i = 1; i <= STEPS + 2; i++) begin
      cyc();
      start = 1'b0;
      @(negedge clk);
      check({tag, "_acc_clr"}, int'(acc_clr), int'(i == 1));
      check({tag, "_step_en"}, int'(step_en), int'(i <= STEPS));
      if (i <= STEPS) check({tag, "_cnt"}, int'(cnt), i - 1);
      check({tag, "_first"}, int'(first), int'(i == 1));
      check({tag, "_last"}, int'(last), int'(i == STEPS));
      check({tag, "_rvalid"}, int'(result_valid), int'(i == STEPS + 1));
      check({tag, "_busy"}, int'(busy), int'(i <= STEPS + 1));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cnt", int'(cnt), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_acc_clr", int'(acc_clr), 0);
    check("rst_rvalid", int'(result_valid), 0);
    rst = 1'b0;
    repeat (2) cyc();

    free_run("free");

    // Operand stall: 3 cycles with cnt at 7.
    cyc();
    start = 1'b1; src_valid = 1'b1; sink_ready = 1'b1;
    push_pass();
    for (int i = 1; i <= STEPS + 5; i++) begin
      cyc();
      start = 1'b0;
      src_valid = !(i >= 8 && i <= 10);
      @(negedge clk);
      if (i >= 8 && i <= 10) begin
        check("stall_cnt_hold", int'(cnt), 7);
        check("stall_no_step", int'(step_en), 0);
      end
      check("stall_rvalid", int'(result_valid), int'(i == STEPS + 4));
      check("stall_busy", int'(busy), int'(i <= STEPS + 4));
    end
`ifdef SEQ_STALL_PERF_EN
    check("stall_perf", int'(stall_cycles), 3);
`endif

    // Back-pressure: 5 cycles without sink_ready in DRAIN.
    cyc();
    start = 1'b1; src_valid = 1'b1; sink_ready = 1'b0;
    push_pass();
    for (int i = 1; i <= STEPS + 7; i++) begin
      cyc();
      start = 1'b0;
      sink_ready = (i >= STEPS + 6);
      @(negedge clk);
      if (i >= STEPS + 1 && i <= STEPS + 6) begin
        check("bp_rvalid_hold", int'(result_valid), 1);
        check("bp_cnt_hold", int'(cnt), LC);
      end
      if (i == STEPS + 7) check("bp_idle", int'(busy), 0);
    end
`ifdef SEQ_STALL_PERF_EN
    check("bp_perf", int'(stall_cycles), 5);
`endif

    // Abort at cnt 12 together with start.
    cyc();
    start = 1'b1; src_valid = 1'b1; sink_ready = 1'b1;
    push_pass();
    for (int i = 1; i <= 13; i++) begin
      cyc();
      start = (i == 13);
      abort = (i == 13);
      @(negedge clk);
    end
    check("abort_cnt_at", int'(cnt), 12);
    cyc();
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_cnt", int'(cnt), 0);
    check("abort_rvalid", int'(result_valid), 0);
    check("abort_acc_clr", int'(acc_clr), 0);
    flush();
    // Abort beats start while idle.
    cyc();
    start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_idle_busy", int'(busy), 0);
    check("abort_idle_clr", int'(acc_clr), 0);

    // start while busy (cnt 3, DRAIN, handshake cycle) is ignored.
    base = handshakes;
    cyc();
    start = 1'b1; src_valid = 1'b1; sink_ready = 1'b0;
    push_pass();
    for (int i = 1; i <= STEPS + 5; i++) begin
      cyc();
      start = (i == 4) || (i >= STEPS + 2 && i <= STEPS + 4);
      sink_ready = (i == STEPS + 4);
      @(negedge clk);
      if (i == 4) check("ign_cnt3", int'(cnt), 3);
    end
    start = 1'b0;
    check("ign_busy", int'(busy), 0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      @(negedge clk);
      check("ign_no_clr", int'(acc_clr), 0);
      check("ign_idle", int'(busy), 0);
    end
    check("ign_one_handshake", handshakes - base, 1);

    // Async reset mid-pass at cnt 18.
    cyc();
    start = 1'b1; src_valid = 1'b1; sink_ready = 1'b1;
    push_pass();
    for (int i = 1; i <= 19; i++) begin
      cyc();
      start = 1'b0;
      @(negedge clk);
    end
    check("arst_cnt_before", int'(cnt), 18);
    #2;
    rst = 1'b1;
    #1;
    check("arst_cnt", int'(cnt), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_step", int'(step_en), 0);
    check("arst_rvalid", int'(result_valid), 0);
    check("arst_clr", int'(acc_clr), 0);
    flush();
    cyc();
    @(negedge clk);
    rst = 1'b0;
    free_run("post_rst");

    // Randomized passes against the step/handshake scoreboard.
    for (int p = 0; p < 20; p++) begin
      int d;
      bit done;
      d = 0;
      done = 1'b0;
      cyc();
      start = 1'b1;
      src_valid = ($urandom_range(0, 9) < 7);
      sink_ready = ($urandom_range(0, 9) < 6);
      push_pass();
      for (int c = 0; c < 400 && !done; c++) begin
        cyc();
        start = 1'b0;
        src_valid = ($urandom_range(0, 9) < 7);
        sink_ready = ($urandom_range(0, 9) < 6);
        @(negedge clk);
        if (busy) d++;
        else done = 1'b1;
      end
      check("rand_done", int'(done), 1);
      check("rand_min_len", int'(d >= STEPS + 1), 1);
`ifdef SEQ_STALL_PERF_EN
      check("rand_perf", int'(stall_cycles), d - (STEPS + 1));
`endif
    end
    src_valid = 1'b0;
    sink_ready = 1'b0;
    repeat (3) cyc();

    check("end_steps_left", exp_steps.size(), 0);
    check("end_results_left", exp_results.size(), 0);
    check("end_clr_left", exp_clr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
